// File: rtl/spi_pkg.sv
// Shared SPI definitions: frame-width encodings and helpers used by both
// the transmit and receive shift blocks.
package spi_pkg;

  localparam logic [1:0] DF_8  = 2'b00;
  localparam logic [1:0] DF_16 = 2'b01;
  localparam logic [1:0] DF_32 = 2'b10;

  // Index of the last bit of a frame (frame length minus one).
  function automatic logic [4:0] frame_max(input logic [1:0] df);
    logic [4:0] mx;
    case (df)
      DF_8:    mx = 5'd7;
      DF_16:   mx = 5'd15;
      default: mx = 5'd31;
    endcase
    return mx;
  endfunction

  // Mask covering the low N bits of a frame.
  function automatic logic [31:0] frame_mask(input logic [1:0] df);
    logic [31:0] m;
    case (df)
      DF_8:    m = 32'h0000_00FF;
      DF_16:   m = 32'h0000_FFFF;
      default: m = 32'hFFFF_FFFF;
    endcase
    return m;
  endfunction

  // Converts between wire order and word order. raw[k] is wire bit k.
  // LSB-first: the wire order already is the word order.
  // MSB-first: the frame is mirrored within its N bits.
  // Bits above the frame width come out as zero.
  function automatic logic [31:0] sort_bits(input logic [31:0] raw,
                                            input logic [1:0]  df,
                                            input logic        lsbf);
    logic [31:0] w;
    logic [4:0]  mx;
    mx = frame_max(df);
    w  = '0;
    if (lsbf) begin
      w = raw & frame_mask(df);
    end else begin
      for (int i = 0; i < 32; i++) begin
        if (5'(i) <= mx) w[mx - 5'(i)] = raw[i];
      end
    end
    return w;
  endfunction

endpackage

// File: rtl/serial_crc_new.sv
// Bit-serial CRC generator/checker, shared by the transmit and receive paths.
// One bit per clock while data_valid is high. The register width follows
// crc_mode (8/16/32). The seed is zero, and init clears the register.
module serial_crc_new
  import spi_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        data_in,
  input  logic        data_valid,
  input  logic        init,
  input  logic [1:0]  crc_mode,
  input  logic [31:0] polynomial,
  output logic [31:0] crc_out
);

  logic [31:0] crc_q;
  logic [31:0] crc_d;
  logic [31:0] mask;
  logic [4:0]  top;
  logic        fb;

  // Next CRC state: shift left, then XOR in the polynomial when the
  // top bit XOR the incoming bit is 1. The result is clipped to the width.
  always_comb begin
    top   = frame_max(crc_mode);
    mask  = frame_mask(crc_mode);
    fb    = crc_q[top] ^ data_in;
    crc_d = ({crc_q[30:0], 1'b0} ^ (fb ? polynomial : 32'd0)) & mask;
  end

  // CRC register. init has priority over accumulating a bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          crc_q <= '0;
    else if (init)       crc_q <= '0;
    else if (data_valid) crc_q <= crc_d;
  end

  assign crc_out = crc_q;

endmodule

// File: rtl/spi_rxc.sv
// SPI receive datapath. It samples shift_in on every rising edge of sclk_tx,
// assembles 8/16/32-bit frames and restores the bit order. It also counts
// frames, raises RXNE/overrun, and checks the trailing CRC frame.
module spi_rxc
  import spi_pkg::*;
(
  input  logic        sclk_tx,
  input  logic        spi_tx_rstn,
  input  logic        shift_in,
  input  logic        rx_en,
  input  logic [1:0]  df,
  input  logic        lsbf,
  input  logic [12:0] spi_rnum,
  input  logic        crc_en,
  input  logic [31:0] crc_poly,
  input  logic        rx_rd,
  input  logic        err_clr,
  output logic [31:0] rx_data,
  output logic        rx_valid,
  output logic        rxne,
  output logic        ovr,
  output logic        rx_num_max_en,
  output logic        crc_done,
  output logic        crc_err,
  output logic [31:0] rx_crc_data_out
);

  logic [4:0]  bit_cnt;
  logic [4:0]  max_bit;
  logic [31:0] raw;
  logic [31:0] raw_nxt;
  logic [31:0] word;
  logic [31:0] mask;
  logic [12:0] rx_num_cnt;
  logic        last_bit;
  logic        frame_done;
  logic        crc_frame;
  logic        data_frame;
  logic        crc_match;
  logic        crc_valid;
  logic        crc_init;
  logic [31:0] crc_val;

  assign rx_num_max_en = (rx_num_cnt >= spi_rnum);

  // Frame assembly. The bit sampled on this edge is merged into raw, so the
  // completed word is available on the same edge as its last bit.
  always_comb begin
    max_bit          = frame_max(df);
    mask             = frame_mask(df);
    raw_nxt          = raw;
    raw_nxt[bit_cnt] = shift_in;
    word             = sort_bits(raw_nxt, df, lsbf);
    // ">=" lets a counter that somehow ended up past max still wrap.
    last_bit         = (bit_cnt >= max_bit);
    frame_done       = rx_en & last_bit;
    crc_frame        = frame_done & crc_en & rx_num_max_en;
    data_frame       = frame_done & ~crc_frame;
    crc_match        = (word == (crc_val & mask));
  end

  // Bit counter and raw shift register. Both are cleared while receive is disabled.
  always_ff @(posedge sclk_tx or negedge spi_tx_rstn) begin
    if (!spi_tx_rstn) begin
      bit_cnt <= '0;
      raw     <= '0;
    end else if (!rx_en) begin
      bit_cnt <= '0;
      raw     <= '0;
    end else if (last_bit) begin
      bit_cnt <= '0;
      raw     <= '0;
    end else begin
      bit_cnt <= bit_cnt + 5'd1;
      raw     <= raw_nxt;
    end
  end

  // Frame counter. It saturates once the data-frame count is reached.
  always_ff @(posedge sclk_tx or negedge spi_tx_rstn) begin
    if (!spi_tx_rstn)                      rx_num_cnt <= '0;
    else if (!rx_en)                       rx_num_cnt <= '0;
    else if (frame_done && !rx_num_max_en) rx_num_cnt <= rx_num_cnt + 13'd1;
  end

  // Data frame output. rx_data is always overwritten with the newest frame.
  always_ff @(posedge sclk_tx or negedge spi_tx_rstn) begin
    if (!spi_tx_rstn) begin
      rx_data  <= '0;
      rx_valid <= 1'b0;
    end else begin
      rx_valid <= data_frame;
      if (data_frame) rx_data <= word;
    end
  end

  // RXNE flag. A new frame takes priority over a read on the same edge.
  always_ff @(posedge sclk_tx or negedge spi_tx_rstn) begin
    if (!spi_tx_rstn)    rxne <= 1'b0;
    else if (data_frame) rxne <= 1'b1;
    else if (rx_rd)      rxne <= 1'b0;
  end

  // Sticky overrun flag. It is set when a frame lands in an unread buffer,
  // and setting wins over err_clr.
  always_ff @(posedge sclk_tx or negedge spi_tx_rstn) begin
    if (!spi_tx_rstn)                       ovr <= 1'b0;
    else if (data_frame && rxne && !rx_rd)  ovr <= 1'b1;
    else if (err_clr)                       ovr <= 1'b0;
  end

  // CRC frame check. crc_done pulses once, and crc_err is sticky until err_clr.
  always_ff @(posedge sclk_tx or negedge spi_tx_rstn) begin
    if (!spi_tx_rstn) begin
      crc_done <= 1'b0;
      crc_err  <= 1'b0;
    end else begin
      crc_done <= crc_frame;
      if (crc_frame && !crc_match) crc_err <= 1'b1;
      else if (err_clr)            crc_err <= 1'b0;
    end
  end

  // The CRC only sees data frames. It stops once the frame count is reached.
  assign crc_valid = crc_en & rx_en & ~rx_num_max_en;
  assign crc_init  = ~crc_en;

  serial_crc_new u_crc (
    .clk        (sclk_tx),
    .rst_n      (spi_tx_rstn),
    .data_in    (shift_in),
    .data_valid (crc_valid),
    .init       (crc_init),
    .crc_mode   (df),
    .polynomial (crc_poly),
    .crc_out    (crc_val)
  );

  assign rx_crc_data_out = crc_val;

endmodule

// File: tb/tb_spi_rxc.sv
// Directed bench for spi_rxc. The stimulus pushes the expected frames and CRC
// verdicts into queues, and a negedge monitor pops them on rx_valid / crc_done.
module tb_spi_rxc;

  logic        sclk_tx = 1'b0;
  logic        spi_tx_rstn;
  logic        shift_in;
  logic        rx_en;
  logic [1:0]  df;
  logic        lsbf;
  logic [12:0] spi_rnum;
  logic        crc_en;
  logic [31:0] crc_poly;
  logic        rx_rd;
  logic        err_clr;
  logic [31:0] rx_data;
  logic        rx_valid;
  logic        rxne;
  logic        ovr;
  logic        rx_num_max_en;
  logic        crc_done;
  logic        crc_err;
  logic [31:0] rx_crc_data_out;

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_data_q[$];
  logic        exp_crc_q[$];

  spi_rxc dut (
    .sclk_tx         (sclk_tx),
    .spi_tx_rstn     (spi_tx_rstn),
    .shift_in        (shift_in),
    .rx_en           (rx_en),
    .df              (df),
    .lsbf            (lsbf),
    .spi_rnum        (spi_rnum),
    .crc_en          (crc_en),
    .crc_poly        (crc_poly),
    .rx_rd           (rx_rd),
    .err_clr         (err_clr),
    .rx_data         (rx_data),
    .rx_valid        (rx_valid),
    .rxne            (rxne),
    .ovr             (ovr),
    .rx_num_max_en   (rx_num_max_en),
    .crc_done        (crc_done),
    .crc_err         (crc_err),
    .rx_crc_data_out (rx_crc_data_out)
  );

  always #5 sclk_tx = ~sclk_tx;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every output event must match the next queued expectation.
  always @(negedge sclk_tx) begin
    if (rx_valid === 1'b1) begin
      if (exp_data_q.size() == 0) begin
        total++; bad++;
        $display("FAIL rx_valid_unexpected: got data 0x%0h expected no frame", rx_data);
      end else begin
        chk("rx_data", rx_data, exp_data_q.pop_front());
      end
    end
    if (crc_done === 1'b1) begin
      if (exp_crc_q.size() == 0) begin
        total++; bad++;
        $display("FAIL crc_done_unexpected: got crc_err %0b expected no pulse", crc_err);
      end else begin
        chk("crc_err_at_done", {31'd0, crc_err}, {31'd0, exp_crc_q.pop_front()});
      end
    end
  end

  // Drive n bits of v in wire order on successive negedges.
  task automatic send_frame(input logic [31:0] v, input int n, input logic lsb_first);
    for (int k = 0; k < n; k++) begin
      @(negedge sclk_tx);
      rx_en    = 1'b1;
      shift_in = lsb_first ? v[k] : v[n-1-k];
    end
  endtask

  // Stop receiving at the negedge where the last completion is visible.
  task automatic end_burst();
    @(negedge sclk_tx);
    rx_en    = 1'b0;
    shift_in = 1'b0;
  endtask

  task automatic pulse_rd();
    @(negedge sclk_tx); rx_rd = 1'b1;
    @(negedge sclk_tx); rx_rd = 1'b0;
  endtask

  task automatic pulse_clr();
    @(negedge sclk_tx); err_clr = 1'b1;
    @(negedge sclk_tx); err_clr = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected test end");
    $fatal(1, "watchdog expired");
  end

  initial begin
    spi_tx_rstn = 1'b0;
    shift_in = 1'b0; rx_en = 1'b0; df = 2'b00; lsbf = 1'b0;
    spi_rnum = 13'd2; crc_en = 1'b0; crc_poly = 32'h07;
    rx_rd = 1'b0; err_clr = 1'b0;
    #12;
    chk("reset_rx_data", rx_data, 32'h0);
    chk("reset_flags", {26'd0, rx_valid, rxne, ovr, rx_num_max_en, crc_done, crc_err}, 32'h0);
    chk("reset_crc", rx_crc_data_out, 32'h0);
    @(negedge sclk_tx); spi_tx_rstn = 1'b1;
    @(negedge sclk_tx);

    // 8-bit, MSB first: wire 0,0,0,1,1,1,1,1 -> 0x1F
    exp_data_q.push_back(32'h1F);
    send_frame(32'h1F, 8, 1'b0);
    end_burst();
    chk("t1_rxne_set", {31'd0, rxne}, 32'd1);
    pulse_rd();
    chk("t1_rxne_clr", {31'd0, rxne}, 32'd0);

    // Same wire bits, LSB first -> 0xF8
    lsbf = 1'b1;
    exp_data_q.push_back(32'hF8);
    send_frame(32'hF8, 8, 1'b1);
    end_burst();
    chk("t2_ovr", {31'd0, ovr}, 32'd0);
    pulse_rd();
    lsbf = 1'b0;

    // 16-bit back-to-back without a read -> overrun
    df = 2'b01;
    exp_data_q.push_back(32'h1234);
    exp_data_q.push_back(32'hABCD);
    send_frame(32'h1234, 16, 1'b0);
    send_frame(32'hABCD, 16, 1'b0);
    end_burst();
    chk("t3_ovr_set", {31'd0, ovr}, 32'd1);
    chk("t3_rx_data", rx_data, 32'hABCD);
    pulse_clr();
    chk("t3_ovr_clr", {31'd0, ovr}, 32'd0);
    chk("t3_rxne_kept", {31'd0, rxne}, 32'd1);
    pulse_rd();

    // CRC-8 poly 0x07, frames 0x01, 0x02 -> CRC 0x1B (hand computed)
    df = 2'b00;
    @(negedge sclk_tx); crc_en = 1'b1;
    chk("t4_max_en_low", {31'd0, rx_num_max_en}, 32'd0);
    exp_data_q.push_back(32'h01);
    exp_data_q.push_back(32'h02);
    exp_crc_q.push_back(1'b0);
    send_frame(32'h01, 8, 1'b0);
    send_frame(32'h02, 8, 1'b0);
    send_frame(32'h1B, 8, 1'b0);
    end_burst();
    chk("t4_max_en", {31'd0, rx_num_max_en}, 32'd1);
    chk("t4_crc_err", {31'd0, crc_err}, 32'd0);
    chk("t4_rx_data", rx_data, 32'h02);
    chk("t4_crc_val", rx_crc_data_out, 32'h1B);
    @(negedge sclk_tx); crc_en = 1'b0;
    @(negedge sclk_tx); crc_en = 1'b1;
    chk("t4_crc_reinit", rx_crc_data_out, 32'h0);
    exp_data_q.push_back(32'h01);
    exp_data_q.push_back(32'h02);
    exp_crc_q.push_back(1'b1);
    send_frame(32'h01, 8, 1'b0);
    send_frame(32'h02, 8, 1'b0);
    send_frame(32'h1A, 8, 1'b0);
    end_burst();
    chk("t4_crc_err_set", {31'd0, crc_err}, 32'd1);
    @(negedge sclk_tx); crc_en = 1'b0;
    pulse_clr();
    chk("t4_crc_err_clr", {31'd0, crc_err}, 32'd0);
    pulse_rd();

    // rx_en dropped after 3 bits: the partial frame must leave no residue
    send_frame(32'h7, 3, 1'b0);
    end_burst();
    @(negedge sclk_tx);
    exp_data_q.push_back(32'h5A);
    send_frame(32'h5A, 8, 1'b0);
    end_burst();
    chk("t5_rx_data", rx_data, 32'h5A);
    pulse_rd();

    // Reset mid-frame with rxne and ovr set
    exp_data_q.push_back(32'h11);
    exp_data_q.push_back(32'h22);
    send_frame(32'h11, 8, 1'b0);
    send_frame(32'h22, 8, 1'b0);
    send_frame(32'hF, 4, 1'b0);
    chk("t6_pre_flags", {30'd0, rxne, ovr}, 32'h3);
    #2 spi_tx_rstn = 1'b0;
    #1;
    chk("t6_rst_data", rx_data, 32'h0);
    chk("t6_rst_flags", {26'd0, rx_valid, rxne, ovr, rx_num_max_en, crc_done, crc_err}, 32'h0);
    @(negedge sclk_tx); rx_en = 1'b0;
    @(negedge sclk_tx); spi_tx_rstn = 1'b1;
    exp_data_q.push_back(32'hC3);
    send_frame(32'hC3, 8, 1'b0);
    end_burst();
    chk("t6_post_flags", {30'd0, rxne, ovr}, 32'h2);
    chk("t6_post_data", rx_data, 32'hC3);

    @(negedge sclk_tx);
    chk("sb_data_drained", exp_data_q.size(), 32'd0);
    chk("sb_crc_drained", exp_crc_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
